// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter sequencer with IDLE / RUN / HALT control.
//
// Purpose:
//   Steps a program counter through instruction memory. It supports absolute
//   jumps through an external jump-target lookup table, a stall hold and an
//   end-of-program halt. It also counts retired instructions, saturating at
//   16'hFFFF.
//
// Ports:
//   clk       in   1   clock; all state updates on the rising edge
//   reset     in   1   asynchronous active-high reset
//   start     in   1   begin execution at START_ADDR (ignored while running)
//   stall     in   1   hold PC and counter this cycle (RUN only)
//   halt      in   1   current instruction ends the program (RUN only)
//   branch    in   1   jump to target this cycle (RUN only)
//   lut_idx   in   4   jump-table index from the decoder
//   lut_addr  out  4   index to the lookup table, combinational copy of lut_idx
//   target    in   D   jump address returned by the lookup table
//   prog_ctr  out  D   current instruction address (registered)
//   running   out  1   high while in RUN (registered)
//   done      out  1   high while in HALT (registered)
//   instr_cnt out  16  instructions retired since the last start (registered)

module pc_sequencer #(
    parameter int unsigned D          = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         halt,
    input  logic         branch,
    input  logic [3:0]   lut_idx,
    output logic [3:0]   lut_addr,
    input  logic [D-1:0] target,
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic [15:0]  instr_cnt
);

    localparam logic [D-1:0] START_PC = D'(START_ADDR);
    localparam logic [D-1:0] PC_ONE   = {{(D-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_nxt_s;
    logic [D-1:0] pc_r;
    logic [D-1:0] pc_nxt_s;
    logic [15:0]  cnt_r;
    logic [15:0]  cnt_nxt_s;
    logic [15:0]  cnt_inc_s;
    logic         running_r;
    logic         done_r;

    // The lookup table is addressed directly so target returns in the same cycle.
    assign lut_addr = lut_idx;

    // Saturating increment of the retired-instruction counter.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r == 16'hFFFF) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + 16'd1;
        end
    end

    // Next-state, next-PC and next-count selection (stall > halt > branch > step).
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = START_PC;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = state_r;
                    pc_nxt_s    = pc_r;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = pc_r;
                    cnt_nxt_s   = cnt_r;
                end else if (halt) begin
                    // The halting instruction retires but the PC stays on it.
                    state_nxt_s = ST_HALT;
                    pc_nxt_s    = pc_r;
                    cnt_nxt_s   = cnt_inc_s;
                end else if (branch) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = target;
                    cnt_nxt_s   = cnt_inc_s;
                end else begin
                    // Natural D-bit overflow gives the wrap from 2^D-1 to 0.
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = pc_r + PC_ONE;
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = START_PC;
                cnt_nxt_s   = 16'd0;
            end
        endcase
    end

    // State, PC, counter and status-flag registers; flags are decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= START_PC;
            cnt_r     <= 16'd0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
            done_r    <= (state_nxt_s == ST_HALT);
        end
    end

    assign prog_ctr  = pc_r;
    assign instr_cnt = cnt_r;
    assign running   = running_r;
    assign done      = done_r;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter D, default 10, width of the program counter and branch target.
REQ-002 Parameter START_ADDR, default 0, PC value loaded on reset and on every start.
REQ-003 Port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port start, input, 1, begins execution at START_ADDR, sampled on a rising clk edge.
REQ-006 Port stall, input, 1, holds PC and counter for the current cycle.
REQ-007 Port halt, input, 1, end-of-program indication from the decoder for the current instruction.
REQ-008 Port branch, input, 1, take an absolute jump to target this cycle.
REQ-009 Port lut_idx, input, 4, jump-table index decoded from the current instruction.
REQ-010 Port lut_addr, output, 4, index driven to the jump-target lookup table.
REQ-011 Port target, input, D, absolute jump address returned by the lookup table for lut_addr.
REQ-012 Port prog_ctr, output, D, current instruction address.
REQ-013 Port running, output, 1, high while in RUN.
REQ-014 Port done, output, 1, high while in HALT.
REQ-015 Port instr_cnt, output, 16, count of retired instructions since the last start.

Function
REQ-016 lut_addr SHALL equal lut_idx combinationally, with no register, so that target is valid in the same cycle.
REQ-017 The block SHALL implement a state machine with states IDLE, RUN and HALT; running is high only in RUN, and done is high only in HALT.
REQ-018 In IDLE: start=1 -> RUN, with prog_ctr<=START_ADDR and instr_cnt<=0; otherwise all state holds.
REQ-019 In RUN, the next-state priority SHALL be stall > halt > branch > increment.
REQ-020 In RUN with stall=1: prog_ctr, instr_cnt and state SHALL hold; halt and branch are ignored.
REQ-021 In RUN with halt=1: state <= HALT, prog_ctr holds at the halting instruction, and instr_cnt increments.
REQ-022 In RUN with branch=1: prog_ctr <= target (a self-jump, target==prog_ctr, is legal), and instr_cnt increments.
REQ-023 Otherwise in RUN: prog_ctr <= (prog_ctr+1) mod 2^D, so 2^D-1 wraps to 0, and instr_cnt increments.
REQ-024 instr_cnt SHALL saturate at 16'hFFFF; it does not wrap.
REQ-025 start in RUN SHALL be ignored.
REQ-026 In HALT: start=1 -> RUN, with prog_ctr<=START_ADDR and instr_cnt<=0; otherwise all state holds and instr_cnt stays readable.
REQ-027 In IDLE and HALT, branch, halt and stall SHALL have no effect.
REQ-028 Any state change SHALL become visible on the outputs one cycle after the sampling edge, with no combinational path from inputs to prog_ctr, running or done.

Reset
REQ-029 reset=1 SHALL immediately, independent of clk, force state=IDLE, prog_ctr=START_ADDR, instr_cnt=0, running=0 and done=0.
REQ-030 Reset asserted mid-RUN or mid-HALT SHALL abandon execution; start is required to resume.
REQ-031 After reset deasserts, the first edge SHALL behave as IDLE.

Verification
REQ-032 Reset, then start pulse, then 5 idle cycles -> prog_ctr 0,1,2,3,4,5; running=1; instr_cnt=5.
REQ-033 In RUN at prog_ctr=7, drive branch=1, lut_idx=4, target=120 -> lut_addr=4 the same cycle; next prog_ctr=120; following cycle 121.
REQ-034 At prog_ctr=10, drive branch=1, halt=1, stall=1 for 1 cycle, then branch=1, halt=1 -> first cycle holds at 10; then HALT with prog_ctr=10 and done=1; further branch has no effect.
REQ-035 Force prog_ctr to 1023 (D=10) via branch target=1023, then increment -> prog_ctr=0 and running stays 1.
REQ-036 In HALT, start=1 -> prog_ctr=0, instr_cnt=0, running=1, done=0; reset asserted between edges mid-RUN -> outputs return to reset values before the next edge.
REQ-037 Run 65540 non-stalled cycles -> instr_cnt holds at 16'hFFFF.
